// File: rtl/gDefine.sv
// rtl/gDefine.sv - shared vector types and writeback source indices
`ifndef VEC_WIDTH
`define VEC_WIDTH 8
`endif

package gDefine;
    localparam int LANE_W = 32;

    typedef logic [`VEC_WIDTH*LANE_W-1:0] Vector_t;
    typedef logic [`VEC_WIDTH-1:0]        Mask_t;

    localparam int NUM_WB_SRC = 3;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_TEX = 2'd2
    } wb_src_e;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant with pointer advancing past the winner
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);
    localparam logic [PW-1:0] LAST  = PW'(N - 1);
    localparam logic [PW:0]   NSIZE = (PW + 1)'(N);

    logic [PW-1:0] ptr;
    logic [PW:0]   sum;
    logic          found;

    // Scan upward from ptr, wrapping at N; the first valid requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW + 1)'(k);
            if (sum >= NSIZE) begin
                sum = sum - NSIZE;
            end
            if (!found && !rst && req[sum[PW-1:0]]) begin
                gnt[sum[PW-1:0]] = 1'b1;
                gnt_idx          = sum[PW-1:0];
                found            = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - arbitrated issue stage for the vector RF write port
module rf_write_arbiter
    import gDefine::*;
#(
    parameter int NUM_REQ = gDefine::NUM_WB_SRC,
    parameter int SIZE    = 2048,
    parameter int SIZE_L  = $clog2(SIZE)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][SIZE_L-1:0]  req_addr,
    input  Vector_t [NUM_REQ-1:0]           req_data,
    input  Mask_t [NUM_REQ-1:0]             req_strb,
    output logic [SIZE_L-1:0]               waddr,
    output Vector_t                         din,
    output Mask_t                           strb,
    output logic                            wen,
    input  logic [2:0][SIZE_L-1:0]          rd_addr,
    output logic [2:0]                      rd_hazard
);
    localparam int PW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      gnt_idx;
    logic               wen_q;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;

    // A zero-strobe winner is consumed but never raises the RAM enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q <= 1'b0;
            waddr <= '0;
            din   <= '0;
            strb  <= '0;
        end else if (|gnt) begin
            wen_q <= |req_strb[gnt_idx];
            waddr <= req_addr[gnt_idx];
            din   <= req_data[gnt_idx];
            strb  <= req_strb[gnt_idx];
        end else begin
            wen_q <= 1'b0;
        end
    end

    // The write registered just before reset rises must not reach the RAM.
    assign wen = wen_q & ~rst;

    always_comb begin
        rd_hazard = '0;
        for (int k = 0; k < 3; k++) begin
            rd_hazard[k] = wen & (waddr == rd_addr[k]);
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed-vector bench for rf_write_arbiter
module tb_rf_write_arbiter;
    import gDefine::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2:0]           req_valid;
    logic [2:0]           req_ready;
    logic [2:0][10:0]     req_addr;
    Vector_t [2:0]        req_data;
    Mask_t [2:0]          req_strb;
    logic [10:0]          waddr;
    Vector_t              din;
    Mask_t                strb;
    logic                 wen;
    logic [2:0][10:0]     rd_addr;
    logic [2:0]           rd_hazard;

    int vectors     = 0;
    int miscompares = 0;

    Vector_t mem [0:2047];

    localparam Vector_t DATA_A = {8{32'hA000_0005}};
    localparam Vector_t DATA_B = {8{32'hB000_000C}};
    localparam Vector_t DATA_C = {8{32'hC0C0_C0C0}};
    localparam Vector_t DATA_D = {8{32'hD0D0_D0D0}};
    localparam Vector_t MERGED = {{4{32'hD0D0_D0D0}}, {4{32'hC0C0_C0C0}}};

    rf_write_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_strb  (req_strb),
        .waddr     (waddr),
        .din       (din),
        .strb      (strb),
        .wen       (wen),
        .rd_addr   (rd_addr),
        .rd_hazard (rd_hazard)
    );

    always #5 clk = ~clk;

    // RAM behaviour: lane-masked write committed at the end of the wen cycle.
    always @(posedge clk) begin
        if (wen === 1'b1) begin
            for (int l = 0; l < 8; l++) begin
                if (strb[l]) mem[waddr][l*32 +: 32] <= din[l*32 +: 32];
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 3'b111;
        req_addr  = '0;
        req_data  = '0;
        req_strb  = '1;
        rd_addr   = {3{11'd2047}};
        for (int i = 0; i < 2048; i++) mem[i] = '0;

        step();
        #1;
        chk("reset_ready", 256'(req_ready), 256'(3'b000));
        chk("reset_wen", 256'(wen), 256'(1'b0));
        chk("reset_waddr", 256'(waddr), 256'(11'd0));
        chk("reset_din", din, 256'd0);
        chk("reset_strb", 256'(strb), 256'(8'h00));
        chk("reset_hazard", 256'(rd_hazard), 256'(3'b000));

        // Single request from requester 0
        step();
        rst         = 1'b0;
        req_valid   = 3'b001;
        req_addr[0] = 11'd5;
        req_data[0] = DATA_A;
        req_strb[0] = 8'hFF;
        #1;
        chk("single_ready", 256'(req_ready), 256'(3'b001));
        step();
        chk("single_wen", 256'(wen), 256'(1'b1));
        chk("single_waddr", 256'(waddr), 256'(11'd5));
        chk("single_din", din, DATA_A);
        req_valid = 3'b000;
        #1;
        chk("idle_ready", 256'(req_ready), 256'(3'b000));
        step();
        chk("idle_wen", 256'(wen), 256'(1'b0));
        chk("idle_waddr_hold", 256'(waddr), 256'(11'd5));

        // All three valid from reset: grants 0,1,2,0,1,2
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = 11'(20 + i);
            req_data[i] = {8{32'(32'h1000_0000 + i)}};
            req_strb[i] = 8'hFF;
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rr_ready_%0d", c), 256'(req_ready), 256'(3'b001 << (c % 3)));
            step();
            chk($sformatf("rr_waddr_%0d", c), 256'(waddr), 256'(20 + (c % 3)));
            chk($sformatf("rr_wen_%0d", c), 256'(wen), 256'(1'b1));
        end
        req_valid = 3'b000;
        chk("rr_ptr_wrap", 256'(dut.u_arb.ptr), 256'(2'd0));

        // Zero-strobe request on requester 1
        req_valid   = 3'b010;
        req_strb[1] = 8'h00;
        #1;
        chk("zstrb_ready", 256'(req_ready), 256'(3'b010));
        step();
        req_valid = 3'b000;
        chk("zstrb_wen", 256'(wen), 256'(1'b0));
        chk("zstrb_ptr", 256'(dut.u_arb.ptr), 256'(2'd2));

        // Hazard window: write to 12 from requester 2
        req_valid   = 3'b100;
        req_addr[2] = 11'd12;
        req_data[2] = DATA_B;
        req_strb[2] = 8'hFF;
        #1;
        chk("hz_ready", 256'(req_ready), 256'(3'b100));
        step();
        req_valid  = 3'b000;
        rd_addr[2] = 11'd12;
        #1;
        chk("hz_n1", 256'(rd_hazard), 256'(3'b100));
        step();
        chk("hz_n2", 256'(rd_hazard), 256'(3'b000));
        chk("hz_readback", mem[12], DATA_B);
        rd_addr = {3{11'd2047}};

        // Reset mid-stream just after the grant to 1
        for (int i = 0; i < 3; i++) req_strb[i] = 8'hFF;
        req_valid = 3'b111;
        #1;
        chk("mid_ready0", 256'(req_ready), 256'(3'b001));
        step();
        #1;
        chk("mid_ready1", 256'(req_ready), 256'(3'b010));
        step();
        rst        = 1'b1;
        rd_addr[0] = 11'd21;
        #1;
        chk("mid_rst_wen", 256'(wen), 256'(1'b0));
        chk("mid_rst_ready", 256'(req_ready), 256'(3'b000));
        chk("mid_rst_hazard", 256'(rd_hazard), 256'(3'b000));
        step();
        rst     = 1'b0;
        rd_addr = {3{11'd2047}};
        #1;
        chk("mid_after_ready", 256'(req_ready), 256'(3'b001));

        // Same-address race between requesters 0 and 1
        req_valid   = 3'b011;
        req_addr[0] = 11'd7;
        req_data[0] = DATA_C;
        req_strb[0] = 8'h0F;
        req_addr[1] = 11'd7;
        req_data[1] = DATA_D;
        req_strb[1] = 8'hF0;
        #1;
        chk("race_ready0", 256'(req_ready), 256'(3'b001));
        step();
        chk("race_wen0", 256'(wen), 256'(1'b1));
        chk("race_strb0", 256'(strb), 256'(8'h0F));
        #1;
        chk("race_ready1", 256'(req_ready), 256'(3'b010));
        step();
        req_valid = 3'b000;
        chk("race_wen1", 256'(wen), 256'(1'b1));
        chk("race_strb1", 256'(strb), 256'(8'hF0));
        chk("race_waddr1", 256'(waddr), 256'(11'd7));
        step();
        chk("race_wen_off", 256'(wen), 256'(1'b0));
        chk("race_merged", mem[7], MERGED);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Round-robin arbiter and issue stage for the single write port of the 3-read/1-write vector register RAM. Several writeback sources (ALU lanes, load unit, texture unit) request vector writes. The block grants one request per cycle and registers the winner's address, data and byte-lane strobe onto the RAM write port. It also flags read addresses that collide with the write currently being issued, so the operand stage can stall or forward.

## Interface
- NUM_REQ, 3: number of writeback requesters (2..8)
- SIZE, 2048: RAM depth in vectors
- SIZE_L, $clog2(SIZE): address width
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester grant; a write transfers when valid & ready
- req_addr  in  NUM_REQ x SIZE_L  per-requester write address
- req_data  in  NUM_REQ x Vector_t  per-requester write data
- req_strb  in  NUM_REQ x Mask_t  per-requester lane strobe (`VEC_WIDTH bits)
- waddr  out  SIZE_L  to RAM write address, registered
- din  out  Vector_t  to RAM write data, registered
- strb  out  Mask_t  to RAM lane strobe, registered
- wen  out  1  to RAM write enable, registered
- rd_addr  in  3 x SIZE_L  read addresses being presented to RAM ports 0..2 this cycle
- rd_hazard  out  3  rd_hazard[k]=1 when wen & (waddr==rd_addr[k])

## Operation
- Grant: combinational round-robin. Search starts at rr_ptr and goes upward, modulo NUM_REQ. The first i with req_valid[i]=1 wins. At most one req_ready bit is high, and only for a valid requester.
- req_ready does not depend on any downstream backpressure. The RAM always accepts, so a valid request is granted whenever it wins.
- Pointer update: on a grant to index g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Issue register:
  - On a grant: waddr/din/strb <= winner's fields.
  - wen <= 1 only if the winner's strb is nonzero.
  - A zero-strobe request is still accepted (ready=1) and consumed, but produces wen=0.
  - No grant: wen <= 0. waddr/din/strb hold their last values.
- Fairness: with all NUM_REQ valid continuously, each requester is granted exactly once every NUM_REQ cycles.
- Requesters may change addr/data/strb while not granted. Only the values present in the grant cycle are captured.
- Same address from two requesters: they are serialised in grant order. The later grant overwrites the enabled lanes.
- rd_hazard compares against the registered waddr/wen, i.e. the write the RAM commits at the end of this cycle. RAM reads in that cycle return pre-write data.
- Reset: rr_ptr=0, wen=0, waddr=0, din=0, strb=0, req_ready=0 while rst=1, rd_hazard=0.
  - A request valid during the reset cycle is not accepted.
  - A write registered in the cycle before rst rises is dropped: wen is forced to 0 in the reset cycle.

## Timing
- Accept in cycle N → wen/waddr/din/strb valid in cycle N+1 → RAM contents updated at end of N+1.
- A read address presented in N+2 returns new data in N+3. Total write-to-readback latency is 3 cycles after acceptance.
- rd_hazard is combinational from registered waddr/wen and input rd_addr, with no added latency.
- Throughput: one write per cycle, sustained.

## Structure
- Vector_t, Mask_t and `VEC_WIDTH stay in gDefine.
- Add gDefine::NUM_WB_SRC = 3 and the requester index enum (WB_ALU, WB_LSU, WB_TEX).
- Sub-module rr_arbiter #(N) holds the pointer and the grant logic: in req[N], out gnt[N] one-hot, pointer advance on |gnt.
- rf_write_arbiter instantiates rr_arbiter, the mux and issue register, and the three hazard comparators.

## Test plan
- Single request: req_valid=001, addr=5, data=A, strb=all-ones, one cycle → ready=001 same cycle; wen=1, waddr=5, din=A next cycle; then wen=0.
- All three valid for 6 cycles from reset → grants 0,1,2,0,1,2 and rr_ptr returns to 0. With different addrs per requester, waddr sequence matches the grant order.
- Zero-strobe request (strb=0) on req 1 → ready[1]=1, next cycle wen=0, rr_ptr advances to 2.
- Hazard: accept write to addr 12 in cycle N, rd_addr[2]=12 in N+1 → rd_hazard=100 in N+1 only; rd_addr=12 again in N+2 → 0, and RAM read then returns new data.
- Reset mid-stream: all valid, assert rst for one cycle after grant to 1 → wen=0 and ready=000 during rst. After rst the first grant goes to 0, not 2.
- Same-address race: req0 and req1 both write addr 7, strb 0x0F / 0xF0 → two consecutive wen cycles, and the final RAM vector merges both lane halves.
